// File: rtl/data_memory_ctrl.sv
// Handshaked byte/half/word data memory with sign/zero-extended loads, alignment/range checks and a post-reset zeroing sweep.
// Response appears in the (WAIT+1)th cycle counting from the acceptance edge; one request in flight, held until rsp_ready.
module data_memory_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64,
  parameter int WAIT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              init_done
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int CNT_W   = (IDX_W > 4) ? IDX_W : 4;
  localparam int WAIT_M1 = (WAIT > 0) ? WAIT - 1 : 0;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                wr_q, uns_q, err_q;
  logic [IDX_W-1:0]    idx_q;
  logic [1:0]          lane_q, size_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                req_ready_q, rsp_valid_q, rsp_error_q, init_done_q;
  logic [DATA_W-1:0]   rsp_rdata_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                in_err_d;
  logic                in_idle, accept, commit;
  logic                a_wr, a_uns, a_err;
  logic [IDX_W-1:0]    a_idx;
  logic [1:0]          a_lane, a_size;
  logic [DATA_W-1:0]   a_wdata;
  logic [DATA_W-1:0]   old_d, wlane_d, merged_d, shifted_d, load_d;
  logic [3:0]          be_d;
  logic                mem_we;
  logic [IDX_W-1:0]    mem_widx;
  logic [DATA_W-1:0]   mem_wdat;

  always_comb begin
    in_err_d = (req_addr >> (2 + IDX_W)) != '0;
    case (req_size)
      2'b00:   ;
      2'b01:   if (req_addr[0]) in_err_d = 1'b1;
      2'b10:   if (req_addr[1:0] != 2'b00) in_err_d = 1'b1;
      default: in_err_d = 1'b1;
    endcase
  end

  // With WAIT=0 the access commits on the acceptance edge, so it must use the live request fields.
  assign in_idle = (state_q == ST_IDLE);
  assign accept  = in_idle && req_valid && req_ready_q;
  assign commit  = (accept && (WAIT == 0)) ||
                   ((state_q == ST_WAIT) && (cnt_q == CNT_W'(WAIT_M1)));

  assign a_wr    = in_idle ? req_write              : wr_q;
  assign a_uns   = in_idle ? req_unsigned           : uns_q;
  assign a_err   = in_idle ? in_err_d               : err_q;
  assign a_idx   = in_idle ? req_addr[2 +: IDX_W]   : idx_q;
  assign a_lane  = in_idle ? req_addr[1:0]          : lane_q;
  assign a_size  = in_idle ? req_size               : size_q;
  assign a_wdata = in_idle ? req_wdata              : wdata_q;

  always_comb begin
    old_d    = mem[a_idx];
    be_d     = 4'b1111;
    wlane_d  = a_wdata;
    case (a_size)
      2'b00: begin
        be_d    = 4'b0001 << a_lane;
        wlane_d = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        be_d    = a_lane[1] ? 4'b1100 : 4'b0011;
        wlane_d = {2{a_wdata[15:0]}};
      end
      default: ;
    endcase
    merged_d = old_d;
    for (int b = 0; b < 4; b++) begin
      if (be_d[b]) merged_d[8*b +: 8] = wlane_d[8*b +: 8];
    end
    shifted_d = old_d >> {a_lane, 3'b000};
    case (a_size)
      2'b00:   load_d = a_uns ? {{(DATA_W-8){1'b0}}, shifted_d[7:0]}
                              : {{(DATA_W-8){shifted_d[7]}}, shifted_d[7:0]};
      2'b01:   load_d = a_uns ? {{(DATA_W-16){1'b0}}, shifted_d[15:0]}
                              : {{(DATA_W-16){shifted_d[15]}}, shifted_d[15:0]};
      default: load_d = old_d;
    endcase
  end

  assign mem_we   = (state_q == ST_INIT) || (commit && a_wr && !a_err);
  assign mem_widx = (state_q == ST_INIT) ? cnt_q[IDX_W-1:0] : a_idx;
  assign mem_wdat = (state_q == ST_INIT) ? '0 : merged_d;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      lane_q      <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (cnt_q == CNT_W'(DEPTH - 1)) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            init_done_q <= 1'b1;
            req_ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (accept) begin
            wr_q        <= req_write;
            uns_q       <= req_unsigned;
            err_q       <= in_err_d;
            idx_q       <= req_addr[2 +: IDX_W];
            lane_q      <= req_addr[1:0];
            size_q      <= req_size;
            wdata_q     <= req_wdata;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            if (WAIT == 0) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_error_q <= a_err;
              rsp_rdata_q <= (a_err || a_wr) ? '0 : load_d;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (commit) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= a_err;
            rsp_rdata_q <= (a_err || a_wr) ? '0 : load_d;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Randomised + directed bench for data_memory_ctrl, scored against a byte-array model of memory.
module tb_data_memory_ctrl;

  localparam int DEPTH = 64;
  localparam int WAITP = 2;
  localparam int NBYTES = DEPTH * 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_error, init_done;
  logic [31:0] rsp_rdata;

  data_memory_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT(WAITP)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] rd; bit err; } exp_t;
  exp_t        exp_q[$];
  logic [7:0]  mb [NBYTES];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          hold_rsp = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
  endfunction

  // Memory as a flat little-endian byte array; sign extension via arithmetic on the loaded value.
  function automatic void model_access(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                                       input bit uns, input logic [31:0] wdata,
                                       output logic [31:0] rd, output bit err);
    int n;
    logic [31:0] v;
    n   = 1 << size;
    err = (size == 2'b11) || ((addr % n) != 0) || (addr >= NBYTES);
    rd  = 32'h0;
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < n; i++) mb[int'(addr) + i] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[int'(addr) + i]) << (8*i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        rd = v;
      end
    end
  endfunction

  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                        input bit uns, input logic [31:0] wdata, input bit expect_rsp);
    exp_t e;
    int   t;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    t = 0;
    while (!req_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      chk(1'b0, "req_accept_timeout", {31'b0, req_ready}, 32'h1);
      req_valid = 1'b0;
      return;
    end
    if (expect_rsp) begin
      model_access(wr, addr, size, uns, wdata, e.rd, e.err);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk(1'b0, "drain_timeout", exp_q.size(), 32'h0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_init(input string name);
    int done_at;
    bit rdy_early;
    done_at = 0;
    rdy_early = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (init_done) begin
        done_at = i;
        break;
      end
      if (req_ready) rdy_early = 1'b1;
    end
    chk(done_at == DEPTH, {name, "_init_cycles"}, done_at, DEPTH);
    chk(!rdy_early, {name, "_ready_during_init"}, {31'b0, rdy_early}, 32'h0);
    chk(req_ready == 1'b1, {name, "_ready_after_init"}, {31'b0, req_ready}, 32'h1);
  endtask

  // Response monitor: picks rsp_ready, and any response it will take at the next edge is scored.
  initial begin
    exp_t e;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_rsp", rsp_rdata, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk(rsp_rdata == e.rd, "rsp_rdata", rsp_rdata, e.rd);
          chk(rsp_error == e.err, "rsp_error", {31'b0, rsp_error}, {31'b0, e.err});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d responses outstanding", exp_q.size());
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] held;
    bit stable;
    logic [31:0] a;
    logic [1:0]  sz;
    int r;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_size = '0; req_unsigned = 1'b0; req_wdata = '0;
    model_clear();
    repeat (3) @(negedge clk);
    chk(req_ready == 1'b0, "rst_req_ready", {31'b0, req_ready}, 32'h0);
    chk(rsp_valid == 1'b0, "rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk(rsp_rdata == 32'h0, "rst_rsp_rdata", rsp_rdata, 32'h0);
    chk(rsp_error == 1'b0, "rst_rsp_error", {31'b0, rsp_error}, 32'h0);
    chk(init_done == 1'b0, "rst_init_done", {31'b0, init_done}, 32'h0);
    rst_n = 1'b1;
    wait_init("first");

    do_req(0, 32'h3C, 2'b10, 0, 0, 1);
    do_req(1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 1);
    do_req(0, 32'h13, 2'b00, 0, 0, 1);
    do_req(0, 32'h11, 2'b00, 1, 0, 1);
    do_req(0, 32'h12, 2'b01, 0, 0, 1);
    do_req(0, 32'h10, 2'b01, 1, 0, 1);
    do_req(1, 32'h11, 2'b00, 0, 32'hFFFFFF55, 1);
    do_req(0, 32'h10, 2'b10, 0, 0, 1);
    do_req(1, 32'h12, 2'b01, 0, 32'hABCD1234, 1);
    do_req(0, 32'h10, 2'b10, 0, 0, 1);
    do_req(1, 32'h00, 2'b10, 0, 32'h01020304, 1);
    do_req(0, 32'h06, 2'b10, 0, 0, 1);
    do_req(1, 32'h01, 2'b01, 0, 32'h0000FFFF, 1);
    do_req(0, 32'h00, 2'b10, 0, 0, 1);
    do_req(0, 32'h04, 2'b11, 0, 0, 1);
    do_req(1, 32'h100, 2'b10, 0, 32'h12345678, 1);
    do_req(0, 32'hFC, 2'b10, 0, 0, 1);
    drain();

    // Latency and stall: response must not move while rsp_ready is held low.
    hold_rsp = 1'b1;
    do_req(0, 32'h10, 2'b10, 0, 0, 1);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      if (rsp_valid) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk(lat == WAITP + 1, "rsp_latency", lat, WAITP + 1);
    held = rsp_rdata;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (!rsp_valid || rsp_rdata != held || req_ready) stable = 1'b0;
    end
    chk(stable, "stall_hold", {31'b0, stable}, 32'h1);
    hold_rsp = 1'b0;
    drain();

    // Reset in the middle of a store's wait states.
    do_req(1, 32'h08, 2'b10, 0, 32'h11223344, 1);
    drain();
    hold_rsp = 1'b1;
    do_req(1, 32'h08, 2'b10, 0, 32'hAAAAAAAA, 0);
    #2 rst_n = 1'b0;
    #1;
    chk(rsp_valid == 1'b0, "midrst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk(req_ready == 1'b0, "midrst_req_ready", {31'b0, req_ready}, 32'h0);
    chk(init_done == 1'b0, "midrst_init_done", {31'b0, init_done}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hold_rsp = 1'b0;
    model_clear();
    wait_init("second");
    do_req(0, 32'h08, 2'b10, 0, 0, 1);
    do_req(0, 32'h10, 2'b10, 0, 0, 1);
    drain();

    for (int it = 0; it < 150; it++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      a  = ($urandom_range(0, 19) == 0) ? 32'($urandom_range(NBYTES, NBYTES + 64))
                                         : 32'($urandom_range(0, 63));
      if (sz != 2'b11 && $urandom_range(0, 9) < 8) a = a & ~((32'h1 << sz) - 32'h1);
      do_req($urandom_range(0, 1), a, sz, $urandom_range(0, 1), $urandom, 1);
    end
    drain();
    chk(exp_q.size() == 0, "all_responses_seen", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised, handshaked data memory for the MIPS datapath. It replaces the bare word RAM with byte/halfword/word access, MIPS-style sign/zero extension, and alignment and range checking. It also adds configurable wait states and a post-reset zeroing sweep. It sits between the MEM stage and the word-addressed storage array.

Parameters:
DATA_W, 32, data word width in bits; fixed at 32 for byte-lane logic.
ADDR_W, 32, byte-address width.
DEPTH, 64, number of words; a power of two, at least 2.
WAIT, 1, extra wait cycles per access, 0..15.

Ports:
clk  input  1  clock, all state updates on posedge.
reset  input  1  asynchronous, active-low; asserted low clears all control state.
req_valid  input  1  request present.
req_ready  output  1  controller can accept a request.
req_write  input  1  1 = store, 0 = load.
req_addr  input  ADDR_W  byte address.
req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
req_unsigned  input  1  zero-extend loads (lbu/lhu); ignored for word.
req_wdata  input  DATA_W  store data; byte/half taken from the low bits.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts the response.
rsp_rdata  output  DATA_W  extended load data; 0 for stores and errors.
rsp_error  output  1  misaligned, out of range, or illegal size.
init_done  output  1  zeroing sweep complete.

Behaviour:
- Reset (reset low, asynchronous):
  - state=INIT, sweep counter=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, init_done=0.
  - Memory contents are not reset directly; the INIT sweep clears them.
- States: INIT, IDLE, WAIT, RESP.
- INIT: writes 0 to mem[cnt] each cycle for cnt=0..DEPTH-1. After DEPTH cycles, go to IDLE and set init_done=1; init_done stays 1 until the next reset. req_ready=0 throughout INIT.
- IDLE: req_ready=1. A request is accepted when req_valid&&req_ready at a posedge. All request fields are captured at acceptance. Next state is WAIT if WAIT>0, else RESP.
- WAIT: the counter counts WAIT cycles, then the state goes to RESP. req_ready=0.
- Access commit: the memory access (write or read-capture) happens on the posedge that enters RESP.
  - Latency: rsp_valid rises WAIT+1 cycles after the acceptance edge.
  - A store is visible to any later accepted load.
- RESP: rsp_valid=1 with rsp_rdata and rsp_error held stable until rsp_valid&&rsp_ready. Then go to IDLE and clear rsp_valid. The next request is accepted no earlier than the following cycle; there is no pipelining.
- Indexing:
  - Word index = req_addr[2 +: log2(DEPTH)].
  - Out of range if any req_addr bit at position 2+log2(DEPTH) or above is set.
- Errors: size 11, half with addr[0]=1, word with addr[1:0]!=0, or out of range.
  - rsp_error=1 and rsp_rdata=0.
  - No memory write occurs.
  - Wait-state timing is unchanged.
- Lanes (little-endian):
  - Byte lane = addr[1:0].
  - Half occupies bytes {addr[1],0} and {addr[1],1}.
  - Stores modify only the addressed bytes; other bytes are preserved.
- Loads: the byte or half is right-justified, then sign-extended (req_unsigned=0) or zero-extended. Word loads are returned unmodified.
- Successful stores: rsp_rdata=0, rsp_error=0.
- Reset mid-operation (any state): the in-flight request is dropped with no response. An uncommitted store is not written. The INIT sweep restarts and re-zeroes the full memory.
- req_valid outside IDLE is ignored; the requester holds it.

Test Plan:
- Release reset -> init_done rises exactly DEPTH(64) cycles later, req_ready=0 until then; lw 0x3C -> rsp_rdata=0x00000000, rsp_error=0.
- sw 0xDEADBEEF @0x10; lb 0x13 -> 0xFFFFFFDE; lbu 0x11 -> 0x000000BE; lh 0x12 -> 0xFFFFDEAD; lhu 0x10 -> 0x0000BEEF.
- sb 0x55 @0x11, then lw 0x10 -> 0xDEAD55EF; sh 0x1234 @0x12, then lw 0x10 -> 0x123455EF.
- lw 0x06, sh 0x01, and a req_size=11 request -> rsp_error=1, rsp_rdata=0; the sh also leaves memory unchanged. sw 0x100 with DEPTH=64 -> rsp_error=1.
- WAIT=2: rsp_valid rises 3 cycles after acceptance; hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata remain stable and req_ready=0 throughout.
- Assert reset during WAIT of a sw 0xAAAAAAAA @0x8 -> rsp_valid=0 immediately. After the sweep, lw 0x8 -> 0x00000000.
